neb_add_arb: RTL and testbench



---
 rtl/neb_pkg.sv | 19 +
 rtl/neb_add_arb_if.sv | 37 +++
 rtl/neb_rr_pick.sv | 42 ++++
 rtl/neb_add_arb.sv | 116 +++++++++++
 tb/tb_neb_add_arb.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/neb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : neb_pkg                                                   |
// | Brief    : Shared types and default sizes for the shared-adder tile. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package neb_pkg;

    localparam int NEB_W    = 8;
    localparam int NEB_NREQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/neb_add_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : neb_add_arb_if                                            |
// | Brief    : Request/grant and valid/ready response bundle.            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface neb_add_arb_if
    import neb_pkg::*;
#(
    parameter int NREQ = NEB_NREQ,
    parameter int W    = NEB_W
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_carry;

    // slave is the arbiter side; master is the requester/consumer side
    modport slave (
        input  req, req_a, req_b, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );

    modport master (
        output req, req_a, req_b, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );

endinterface
`default_nettype wire

// File: rtl/neb_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : neb_rr_pick                                               |
// | Brief    : Combinational round-robin selector, search from ptr up.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module neb_rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int w_j;

    // Walk offsets high to low so the smallest offset from ptr wins last.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        w_j    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = int'(ptr) + k;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (req[w_j]) begin
                idx = w_j[IDW-1:0];
                any = 1'b1;
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/neb_add_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : neb_add_arb                                               |
// | Brief    : Round-robin scheduler sharing one adder among requesters. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module neb_add_arb
    import neb_pkg::*;
#(
    parameter int NREQ = NEB_NREQ,
    parameter int W    = NEB_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    neb_add_arb_if.slave  bus,
    output logic          busy,
    output logic [7:0]    op_cnt
);

    localparam int IDW = $clog2(NREQ);

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_cap_id;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [IDW-1:0]  r_rsp_id;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_valid;
    logic            r_busy;
    logic [7:0]      r_op_cnt;

    logic [NREQ-1:0] w_win_oh;
    logic [IDW-1:0]  w_win_idx;
    logic            w_any;
    logic            w_start;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic [W:0]      w_add;

    neb_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (bus.req),
        .ptr    (r_ptr),
        .onehot (w_win_oh),
        .idx    (w_win_idx),
        .any    (w_any)
    );

    assign w_start = (r_state == ST_IDLE) && ena && w_any;
    assign w_a     = bus.req_a[int'(w_win_idx)*W +: W];
    assign w_b     = bus.req_b[int'(w_win_idx)*W +: W];
    assign w_add   = {1'b0, r_a} + {1'b0, r_b};

    // Grant is a combinational pulse so operands are captured in the same cycle.
    assign bus.gnt       = w_start ? w_win_oh : '0;
    assign bus.rsp_valid = r_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_carry = r_carry;
    assign busy          = r_busy;
    assign op_cnt        = r_op_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_cap_id <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rsp_id <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_op_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_a      <= w_a;
                        r_b      <= w_b;
                        r_cap_id <= w_win_idx;
                        r_ptr    <= (w_win_idx == IDW'(NREQ - 1)) ? '0
                                                                  : w_win_idx + IDW'(1);
                        r_busy   <= 1'b1;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_sum    <= w_add[W-1:0];
                    r_carry  <= w_add[W];
                    r_rsp_id <= r_cap_id;
                    r_valid  <= 1'b1;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_valid  <= 1'b0;
                        r_busy   <= 1'b0;
                        r_op_cnt <= r_op_cnt + 8'd1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neb_add_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_neb_add_arb                                            |
// | Brief    : Directed scoreboard bench for neb_add_arb.                |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_neb_add_arb;
    import neb_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       busy;
    logic [7:0] op_cnt;

    neb_add_arb_if #(.NREQ(NREQ), .W(W)) bus ();

    neb_add_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .bus    (bus),
        .busy   (busy),
        .op_cnt (op_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W:0]     res;
    } exp_t;

    exp_t           q[$];
    int             gorder[$];
    bit             rec_order;
    int             m_state;
    logic [IDW-1:0] m_ptr;
    logic [7:0]     m_cnt;
    int             checks;
    int             failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    // One clock: check outputs at negedge against the reference, then advance it.
    task automatic step();
        logic [NREQ-1:0] eg;
        int              win;
        int              j;
        exp_t            e;
        @(negedge clk);
        eg  = '0;
        win = -1;
        if (m_state == 0 && ena) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (int'(m_ptr) + k) % NREQ;
                if (win < 0 && bus.req[j]) win = j;
            end
        end
        if (win >= 0) eg[win] = 1'b1;
        chk("gnt", 32'(bus.gnt), 32'(eg));
        chk("busy", 32'(busy), 32'(m_state != 0));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_state == 2));
        chk("op_cnt", 32'(op_cnt), 32'(m_cnt));
        if (m_state == 2) begin
            chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
                chk("rsp_sum", 32'(bus.rsp_sum), 32'(q[0].res[W-1:0]));
                chk("rsp_carry", 32'(bus.rsp_carry), 32'(q[0].res[W]));
            end
        end
        case (m_state)
            0: if (win >= 0) begin
                e.id  = IDW'(win);
                e.res = {1'b0, bus.req_a[win*W +: W]} + {1'b0, bus.req_b[win*W +: W]};
                q.push_back(e);
                m_ptr   = IDW'((win + 1) % NREQ);
                m_state = 1;
                if (rec_order) gorder.push_back(win);
            end
            1: m_state = 2;
            default: if (bus.rsp_ready) begin
                void'(q.pop_front());
                m_cnt   = m_cnt + 8'd1;
                m_state = 0;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_id"}, 32'(bus.rsp_id), 32'd0);
        chk({tag, "_sum"}, 32'(bus.rsp_sum), 32'd0);
        chk({tag, "_carry"}, 32'(bus.rsp_carry), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_opcnt"}, 32'(op_cnt), 32'd0);
    endtask

    initial begin
        int  exp_ord [8];
        bit  seen255;
        bit  wrapped;
        checks        = 0;
        failures      = 0;
        rec_order     = 1'b0;
        m_state       = 0;
        m_ptr         = '0;
        m_cnt         = '0;
        rst_n         = 1'b0;
        ena           = 1'b0;
        bus.req       = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Single request
        ena = 1'b1;
        set_op(0, 8'h12, 8'h34);
        bus.req = 4'b0001;
        step();
        bus.req = 4'b0000;
        repeat (3) step();

        // Overflow cases on requester 2
        set_op(2, 8'hFF, 8'h01);
        bus.req = 4'b0100;
        step();
        bus.req = 4'b0000;
        repeat (2) step();
        set_op(2, 8'h80, 8'h80);
        bus.req = 4'b0100;
        step();
        bus.req = 4'b0000;
        repeat (2) step();

        // Fairness with all requesters active; pointer sits at 3 here
        set_op(0, 8'h01, 8'h02);
        set_op(1, 8'h10, 8'hF0);
        set_op(2, 8'hAA, 8'h55);
        set_op(3, 8'hC3, 8'h7E);
        bus.req   = 4'b1111;
        rec_order = 1'b1;
        repeat (24) step();
        rec_order = 1'b0;
        exp_ord = '{3, 0, 1, 2, 3, 0, 1, 2};
        chk("order_len", 32'(gorder.size()), 32'd8);
        for (int i = 0; i < 8 && i < gorder.size(); i++) begin
            chk("order", 32'(gorder[i]), 32'(exp_ord[i]));
        end

        // Backpressure
        bus.rsp_ready = 1'b0;
        repeat (2) step();
        chk("bp_in_resp", 32'(bus.rsp_valid), 32'd1);
        repeat (5) step();
        bus.rsp_ready = 1'b1;
        repeat (4) step();
        bus.req = 4'b0000;
        for (int n = 0; n < 10 && m_state != 0; n++) step();
        chk("bp_drained", 32'(busy), 32'd0);

        // ena gating
        ena = 1'b0;
        set_op(1, 8'h5A, 8'h33);
        bus.req = 4'b0010;
        repeat (3) step();
        ena = 1'b1;
        step();
        bus.req = 4'b0000;
        ena = 1'b0;
        repeat (2) step();
        step();
        ena = 1'b1;

        // Reset in EXEC abandons the op and returns the pointer to 0
        set_op(0, 8'h11, 8'h22);
        bus.req = 4'b0001;
        step();
        bus.req = 4'b0000;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        m_state = 0;
        m_ptr   = '0;
        m_cnt   = '0;
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_op(3, 8'h7F, 8'h01);
        bus.req = 4'b1000;
        step();
        bus.req = 4'b0000;
        repeat (2) step();

        // op_cnt wrap
        set_op(0, 8'hFE, 8'h03);
        bus.req = 4'b0001;
        seen255 = 1'b0;
        wrapped = 1'b0;
        for (int n = 0; n < 1200 && !wrapped; n++) begin
            step();
            if (m_cnt == 8'd255) seen255 = 1'b1;
            if (seen255 && m_cnt == 8'd0) wrapped = 1'b1;
        end
        chk("wrap_reached", 32'(wrapped), 32'd1);
        chk("op_cnt_wrap", 32'(op_cnt), 32'd0);
        bus.req = 4'b0000;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
